// File: rtl/serializer16.sv
// -----------------------------------------------------------------------------
// serializer16
//
// Converts a 16-bit parallel word into a serial bit stream. Both sides use a
// valid/ready handshake. When the last bit of a word is taken and a new word is
// offered in the same cycle, the next word follows with no idle cycle.
//
// Parameters
//   MSB_FIRST   0: bit 0 goes out first, 1: bit 15 goes out first
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   load_data   parallel word to serialize (16 bits)
//   load_valid  load_data is offered
//   load_ready  a word can be accepted this cycle
//   bit_out     current serial bit
//   bit_valid   bit_out is valid
//   bit_ready   consumer takes bit_out this cycle
//   bit_last    bit_out is the 16th bit of the word
//   busy        a word is held or being shifted
//   word_count  number of fully transmitted words, modulo 256
// -----------------------------------------------------------------------------
module serializer16 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        bit_last,
  output logic        busy,
  output logic [7:0]  word_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e      state_q,      state_d;
  logic [15:0] word_q,       word_d;
  logic [3:0]  idx_q,        idx_d;
  logic [7:0]  word_count_q, word_count_d;

  logic        load_hs_s;
  logic        bit_hs_s;
  logic        at_last_s;
  logic [3:0]  bit_sel_s;

  // Handshake and position decode shared by the next-state and output logic.
  always_comb begin
    at_last_s = (idx_q == 4'd15);
    // load_ready is a function of state, index and bit_ready only, so it can
    // never form a combinational loop through the producer's load_valid.
    if (state_q == IDLE) begin
      load_ready = 1'b1;
    end else begin
      load_ready = at_last_s && bit_ready;
    end
    bit_valid = (state_q == SHIFT);
    busy      = (state_q == SHIFT);
    bit_last  = (state_q == SHIFT) && at_last_s;
    load_hs_s = load_valid && load_ready;
    bit_hs_s  = bit_valid && bit_ready;
  end

  // Select the outgoing bit; the output is forced low while idle.
  always_comb begin
    if (MSB_FIRST) begin
      bit_sel_s = 4'd15 - idx_q;
    end else begin
      bit_sel_s = idx_q;
    end
    if (state_q == SHIFT) begin
      bit_out = word_q[bit_sel_s];
    end else begin
      bit_out = 1'b0;
    end
  end

  // Next-state logic for the IDLE/SHIFT controller and its datapath.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;
    case (state_q)
      IDLE: begin
        if (load_hs_s) begin
          state_d = SHIFT;
          word_d  = load_data;
          idx_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bit_hs_s) begin
          if (at_last_s) begin
            word_count_d = word_count_q + 8'd1;
            if (load_hs_s) begin
              // Back-to-back: the new word replaces the finished one in the
              // same edge, so bit_valid never drops between words.
              state_d = SHIFT;
              word_d  = load_data;
              idx_d   = 4'd0;
            end else begin
              state_d = IDLE;
              idx_d   = 4'd0;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          // Consumer stalled: word and index hold, so bit_out holds too.
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State, word, index and completed-word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= 16'd0;
      idx_q        <= 4'd0;
      word_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;

endmodule
